// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: receiver state encoding and frame line levels.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to RESET_VAL.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/serial_rx.sv
// Asynchronous serial frame receiver (start, DATA_W bits LSB first, optional parity, stop).
// Define SERIAL_RX_PARITY_EN to build in the parity bit and a functional parity_err.
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t         r_state;
  rx_state_t         w_nextState;
  logic              w_rxS;
  logic              w_bitEnd;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sh;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_frameErr;

  rx_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (w_rxS)
  );

  assign w_bitEnd = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (w_rxS == START_LEVEL) w_nextState = ST_START;
      ST_START: if (r_cnt == HALF_CNT)
                  w_nextState = (w_rxS == START_LEVEL) ? ST_DATA : ST_IDLE;
`ifdef SERIAL_RX_PARITY_EN
      ST_DATA:   if (w_bitEnd && r_idx == LAST_IDX) w_nextState = ST_PARITY;
      ST_PARITY: if (w_bitEnd) w_nextState = ST_STOP;
`else
      ST_DATA:   if (w_bitEnd && r_idx == LAST_IDX) w_nextState = ST_STOP;
`endif
      ST_STOP:  if (w_bitEnd) w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Each bit is sampled on the last count of its period; START is half a period so samples land mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh       <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        ST_START:  r_cnt <= (r_cnt == HALF_CNT) ? '0 : r_cnt + 1'b1;
        ST_DATA: begin
          if (w_bitEnd) begin
            r_cnt <= '0;
            r_idx <= r_idx + 1'b1;
            r_sh  <= (r_sh >> 1) | (DATA_W'(w_rxS) << (DATA_W - 1));
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PARITY: r_cnt <= w_bitEnd ? '0 : r_cnt + 1'b1;
        ST_STOP: begin
          if (w_bitEnd) begin
            r_cnt <= '0;
            if (w_rxS == STOP_LEVEL) begin
              r_data  <= r_sh;
              r_valid <= 1'b1;
            end else begin
              r_frameErr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
      endcase
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic r_parFlag;
  logic r_parityErr;

  // The mismatch is latched at the parity sample and reported alongside the stop-bit outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_parFlag   <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      r_parityErr <= 1'b0;
      if (r_state == ST_IDLE)
        r_parFlag <= 1'b0;
      else if (r_state == ST_PARITY && w_bitEnd)
        r_parFlag <= (((^r_sh) ^ w_rxS) != PARITY_ODD[0]);
      if (r_state == ST_STOP && w_bitEnd)
        r_parityErr <= r_parFlag;
    end
  end

  assign parity_err = r_parityErr;
`else
  // Without a parity bit the parity sense has no meaning and the flag is constant 0.
  assign parity_err = 1'b0 & PARITY_ODD[0];
`endif

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frameErr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Randomized self-checking bench for serial_rx; frames are predicted from the frame format and timing rules.
module tb_serial_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 16;
  localparam int PODD   = 0;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  // rx fall to the registered strobe: 2 sync flops, 1 IDLE cycle, half-bit START, then data/parity/stop bits
  localparam int LAT = 3 + CPB / 2 + (DATA_W + 1 + P) * CPB;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              frameErr;
  logic              parityErr;
  logic              busy;

  serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frameErr),
    .parity_err (parityErr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 valid, 1 frame_err, 2 parity_err alone, 3 valid and frame_err together
  typedef struct {
    int cyc;
    int kind;
    int d;
    int pe;
    int busy;
  } ev_t;

  ev_t obsQ[$];
  ev_t expQ[$];
  ev_t monEv;
  int nChecks = 0;
  int nErrors = 0;
  logic [DATA_W-1:0] lastGood = '0;

  always @(negedge clk) begin
    if (valid || frameErr || parityErr) begin
      monEv.cyc  = cyc;
      monEv.kind = valid ? (frameErr ? 3 : 0) : (frameErr ? 1 : 2);
      monEv.d    = int'(data);
      monEv.pe   = int'(parityErr);
      monEv.busy = int'(busy);
      obsQ.push_back(monEv);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic goodParity(input logic [DATA_W-1:0] d);
    return logic'(($countones(d) + PODD) % 2);
  endfunction

  // Drives one complete frame and records the outcome the receiver must produce.
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic parBit,
                               input logic stopBit, input int gap);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.kind = stopBit ? 0 : 1;
    if (stopBit) lastGood = d;
    e.d    = int'(lastGood);
    e.pe   = (P == 1) ? int'((($countones(d) + int'(parBit)) % 2) != PODD) : 0;
    e.busy = 0;
    expQ.push_back(e);
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < DATA_W; i++) begin
      rx = d[i];
      waitCycles(CPB);
    end
    if (P == 1) begin
      rx = parBit;
      waitCycles(CPB);
    end
    rx = stopBit;
    waitCycles(CPB);
    rx = 1'b1;
    waitCycles(gap);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic              stopBit;
    logic              parBit;
    int                gap;
    int                n;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetData", int'(data), 0);
    checkOutput("resetValid", int'(valid), 0);
    checkOutput("resetFrameErr", int'(frameErr), 0);
    checkOutput("resetParityErr", int'(parityErr), 0);
    checkOutput("resetBusy", int'(busy), 0);
    rst = 1'b0;
    waitCycles(5);

    applyStimulus(8'hA5, goodParity(8'hA5), 1'b1, 20);
    applyStimulus(8'h00, goodParity(8'h00), 1'b1, 0);
    applyStimulus(8'hFF, goodParity(8'hFF), 1'b1, 20);
    applyStimulus(8'h3C, goodParity(8'h3C), 1'b0, 30);

    rx = 1'b0;
    waitCycles(4);
    rx = 1'b1;
    checkOutput("glitchBusyHigh", int'(busy), 1);
    waitCycles(30);
    checkOutput("glitchBusyLow", int'(busy), 0);

`ifdef SERIAL_RX_PARITY_EN
    applyStimulus(8'h07, 1'b1, 1'b1, 10);
    applyStimulus(8'h07, 1'b0, 1'b1, 10);
`endif

    for (n = 0; n < 12; n++) begin
      d       = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      stopBit = ($urandom_range(0, 4) != 0);
      parBit  = goodParity(d) ^ ($urandom_range(0, 3) == 0);
      gap     = stopBit ? int'($urandom_range(0, 20)) : CPB + int'($urandom_range(0, 10));
      applyStimulus(d, parBit, stopBit, gap);
    end
    waitCycles(50);

    d  = 8'h5A;
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      waitCycles(CPB);
    end
    rx = d[4];
    waitCycles(CPB / 2);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("midResetData", int'(data), 0);
    checkOutput("midResetValid", int'(valid), 0);
    checkOutput("midResetFrameErr", int'(frameErr), 0);
    checkOutput("midResetParityErr", int'(parityErr), 0);
    checkOutput("midResetBusy", int'(busy), 0);
    rst      = 1'b0;
    rx       = 1'b1;
    lastGood = '0;
    waitCycles(3 * CPB);

    applyStimulus(8'h81, goodParity(8'h81), 1'b1, 20);
    waitCycles(50);

    checkOutput("eventCount", obsQ.size(), expQ.size());
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("ev%0d.cycle", i), obsQ[i].cyc, expQ[i].cyc);
      checkOutput($sformatf("ev%0d.kind", i), obsQ[i].kind, expQ[i].kind);
      checkOutput($sformatf("ev%0d.data", i), obsQ[i].d, expQ[i].d);
      checkOutput($sformatf("ev%0d.parityErr", i), obsQ[i].pe, expQ[i].pe);
      checkOutput($sformatf("ev%0d.busy", i), obsQ[i].busy, expQ[i].busy);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
